controlador_cajero_param: RTL

CONTROLADOR_CAJERO_PARAM -- requirements
Module: controlador_cajero_param

---
 rtl/controlador_cajero_param_if.sv | 34 +++
 rtl/controlador_cajero_param.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/controlador_cajero_param_if.sv
// controlador_cajero_param_if: cajero I/O bundle (card, PIN entry, transaction request, status)
interface controlador_cajero_param_if #(
  parameter int N_DIGITOS = 4,
  parameter int MONTO_W = 32,
  parameter int BAL_W = 64
);
  logic tarjeta_recibida;
  logic tipo_tarjeta;
  logic [4*N_DIGITOS-1:0] pin;
  logic [3:0] digito;
  logic digito_stb;
  logic tipo_transaccion;
  logic [MONTO_W-1:0] monto;
  logic monto_stb;
  logic balance_actualizado;
  logic entregar_dinero;
  logic fondos_insuficientes;
  logic pin_incorrecto;
  logic comision;
  logic advertencia;
  logic bloqueo;
  logic [BAL_W-1:0] balance;
  logic [2:0] estado;
  modport master (
    output tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb, tipo_transaccion, monto, monto_stb,
    input balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, comision,
    input advertencia, bloqueo, balance, estado
  );
  modport slave (
    input tarjeta_recibida, tipo_tarjeta, pin, digito, digito_stb, tipo_transaccion, monto, monto_stb,
    output balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, comision,
    output advertencia, bloqueo, balance, estado
  );
endinterface

// File: rtl/controlador_cajero_param.sv
// controlador_cajero_param: ATM controller with PIN check, lockout, idle timeout and fee-aware deposits/withdrawals
module controlador_cajero_param #(
  parameter int N_DIGITOS = 4,
  parameter int MONTO_W = 32,
  parameter int BAL_W = 64,
  parameter int MAX_INTENTOS = 3,
  parameter int COMISION_VAL = 10,
  parameter logic [BAL_W-1:0] BALANCE_INI = BAL_W'(50000),
  parameter int TIMEOUT = 1000
) (
  input logic clk,
  input logic rst,
  controlador_cajero_param_if.slave bus
);
  localparam int PW = 4 * N_DIGITOS;
  localparam int AW = $clog2(MAX_INTENTOS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {
    ESPERA_TARJETA = 3'd0,
    LEER_PIN = 3'd1,
    ESPERA_MONTO = 3'd2,
    FIN = 3'd3,
    BLOQUEO = 3'd4
  } estado_t;
  estado_t st;
  logic dig_q, mon_q, tipo_l;
  logic [PW-1:0] pin_l, entry, entry_n;
  logic [3:0] cnt;
  logic [AW-1:0] att, att_n;
  logic [TW-1:0] idle;
  logic [BAL_W-1:0] bal;
  logic [BAL_W:0] fee, cost, sum, dep_new;
  logic dig_e, mon_e, timeout, wd_ok, dep_low, dep_sat;
  assign dig_e = bus.digito_stb & ~dig_q;
  assign mon_e = bus.monto_stb & ~mon_q;
  assign entry_n = PW'({entry, bus.digito});
  assign att_n = att + AW'(1);
  assign timeout = idle == TW'(TIMEOUT - 1);
  assign fee = tipo_l ? (BAL_W+1)'(COMISION_VAL) : '0;
  assign cost = (BAL_W+1)'(bus.monto) + fee;
  assign sum = {1'b0, bal} + (BAL_W+1)'(bus.monto);
  assign dep_new = sum - fee;
  assign wd_ok = cost <= {1'b0, bal};
  assign dep_low = sum < fee;
  assign dep_sat = dep_new[BAL_W];
  assign bus.balance = bal;
  assign bus.estado = st;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ESPERA_TARJETA;
      bal <= BALANCE_INI;
      att <= '0;
      idle <= '0;
      cnt <= '0;
      entry <= '0;
      pin_l <= '0;
      tipo_l <= 1'b0;
      dig_q <= 1'b0;
      mon_q <= 1'b0;
      bus.balance_actualizado <= 1'b0;
      bus.entregar_dinero <= 1'b0;
      bus.fondos_insuficientes <= 1'b0;
      bus.pin_incorrecto <= 1'b0;
      bus.comision <= 1'b0;
      bus.advertencia <= 1'b0;
      bus.bloqueo <= 1'b0;
    end else begin
      dig_q <= bus.digito_stb;
      mon_q <= bus.monto_stb;
      idle <= '0;
      bus.balance_actualizado <= 1'b0;
      bus.entregar_dinero <= 1'b0;
      bus.fondos_insuficientes <= 1'b0;
      bus.pin_incorrecto <= 1'b0;
      bus.comision <= 1'b0;
      case (st)
        ESPERA_TARJETA:
          if (bus.tarjeta_recibida) begin
            pin_l <= bus.pin;
            tipo_l <= bus.tipo_tarjeta;
            cnt <= '0;
            st <= LEER_PIN;
          end else begin
            att <= '0;
            bus.advertencia <= 1'b0;
          end
        LEER_PIN:
          if (!bus.tarjeta_recibida) begin
            st <= ESPERA_TARJETA;
            att <= '0;
            bus.advertencia <= 1'b0;
          end else if (dig_e) begin
            entry <= entry_n;
            cnt <= cnt + 4'd1;
            if (cnt == 4'(N_DIGITOS - 1)) begin
              cnt <= '0;
              if (entry_n == pin_l) begin
                att <= '0;
                bus.advertencia <= 1'b0;
                st <= ESPERA_MONTO;
              end else begin
                att <= att_n;
                bus.pin_incorrecto <= 1'b1;
                if (att_n == AW'(MAX_INTENTOS - 1)) bus.advertencia <= 1'b1;
                if (att_n == AW'(MAX_INTENTOS)) begin
                  bus.bloqueo <= 1'b1;
                  st <= BLOQUEO;
                end
              end
            end
          end else if (timeout) st <= ESPERA_TARJETA;
          else idle <= idle + TW'(1);
        ESPERA_MONTO:
          if (!bus.tarjeta_recibida) begin
            st <= ESPERA_TARJETA;
            att <= '0;
            bus.advertencia <= 1'b0;
          end else if (mon_e) begin
            st <= FIN;
            if (bus.tipo_transaccion) begin
              if (wd_ok) begin
                bal <= bal - cost[BAL_W-1:0];
                bus.entregar_dinero <= 1'b1;
                bus.balance_actualizado <= 1'b1;
                bus.comision <= tipo_l;
              end else bus.fondos_insuficientes <= 1'b1;
            end else if (dep_low) bus.fondos_insuficientes <= 1'b1;
            else begin
              bal <= dep_sat ? '1 : dep_new[BAL_W-1:0];
              bus.balance_actualizado <= 1'b1;
              bus.comision <= tipo_l;
            end
          end else if (timeout) st <= ESPERA_TARJETA;
          else idle <= idle + TW'(1);
        FIN:
          if (!bus.tarjeta_recibida) st <= ESPERA_TARJETA;
        BLOQUEO: ;
        default: st <= ESPERA_TARJETA;
      endcase
    end
  end
endmodule
